pipe_rr_sched: RTL

- Shares one fixed-latency, non-stallable datapath pipeline (delay-line style, e.g. a crypto round pipeline) between N_REQ requesters.
- Round-robin issue, one operation per cycle max; requester ID travels alongside in an internal tag delay line.
- Results are buffered in a response FIFO. Credit-based issue guarantees the FIFO never overflows, even though the pipeline cannot stall.

---
 rtl/pipe_rr_sched.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_rr_sched.sv
// rtl/pipe_rr_sched.sv - round-robin issue into a shared fixed-latency pipeline with credit-guarded response FIFO
// Optional counters issue_cnt/stall_cnt are built when PIPE_RR_SCHED_STATS_EN is defined.
module pipe_rr_sched #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   pipe_in_valid,
  output logic [WIDTH-1:0]       pipe_din,
  input  logic [WIDTH-1:0]       pipe_dout,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy
`ifdef PIPE_RR_SCHED_STATS_EN
  ,
  output logic [31:0]            issue_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tag_v_q  [LATENCY];
  logic [ID_W-1:0]  tag_id_q [LATENCY];

  logic [WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id_q   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  logic             issue, grant_found, pop, wr, mem_wr, mem_rd;
  logic [ID_W-1:0]  grant_id;
  logic             exit_v;
  logic [ID_W-1:0]  exit_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Arbitration: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    issue         = grant_found && !rst && (cnt_q < DEPTH_C);
    req_ready     = '0;
    pipe_in_valid = issue;
    pipe_din      = '0;
    if (issue) begin
      req_ready[grant_id] = 1'b1;
      pipe_din            = req_data[int'(grant_id)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  assign exit_v  = tag_v_q[LATENCY-1];
  assign exit_id = tag_id_q[LATENCY-1];
  assign pop     = rsp_valid_q && rsp_ready;
  assign wr      = exit_v;

  // The output register is refilled from memory first, or straight from the
  // pipeline when memory is empty, so ordering is preserved.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    if (!rsp_valid_q || pop) begin
      if (mem_cnt_q != '0) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_data_q[rd_ptr_q];
        rsp_id_d    = mem_id_q[rd_ptr_q];
        mem_rd      = 1'b1;
        mem_wr      = wr;
      end else if (wr) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = pipe_dout;
        rsp_id_d    = exit_id;
      end else begin
        rsp_valid_d = 1'b0;
      end
    end else begin
      mem_wr = wr;
    end
  end

  always_comb begin
    wr_ptr_d  = mem_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = mem_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    case ({mem_wr, mem_rd})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // Credits cover both in-flight and buffered results; issue sees the pre-pop value.
  always_comb begin
    cnt_d = cnt_q;
    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_v_q[k]  <= 1'b0;
        tag_id_q[k] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      tag_v_q[0]  <= issue;
      tag_id_q[0] <= grant_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_data_q[wr_ptr_q] <= pipe_dout;
      mem_id_q[wr_ptr_q]   <= exit_id;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (cnt_q != '0);

`ifdef PIPE_RR_SCHED_STATS_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) issue_cnt_q <= issue_cnt_q + 32'd1;
      if ((|req_valid) && (cnt_q == DEPTH_C)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
